// File: rtl/vga_pattern_pkg.sv
// rtl/vga_pattern_pkg.sv - shared pattern modes and bit-position constants for the scrolling test pattern
//
// Contents:
//   pattern_mode_t   pattern select encoding (CHECKER, BARS, BANDS, XOR)
//   CHECKER_BIT      coordinate bit whose parity forms the checkerboard (16-pixel squares)
//   BAR_*_BASE       low bit of the per-channel slice used by BARS and BANDS
//   XOR_*_BASE       low bit of the per-channel slice taken from mx ^ my
//   PATTERN_TOP_BASE highest slice base; coordinates must cover it plus one colour field

package vga_pattern_pkg;

    typedef enum logic [1:0] {
        CHECKER = 2'd0,
        BARS    = 2'd1,
        BANDS   = 2'd2,
        XOR     = 2'd3
    } pattern_mode_t;

    localparam int CHECKER_BIT = 4;

    localparam int BAR_R_BASE = 4;
    localparam int BAR_G_BASE = 5;
    localparam int BAR_B_BASE = 6;

    localparam int XOR_R_BASE = 3;
    localparam int XOR_G_BASE = 4;
    localparam int XOR_B_BASE = 5;

    localparam int PATTERN_TOP_BASE = 6;

endpackage

// File: rtl/vga_scroll_offset.sv
// rtl/vga_scroll_offset.sv - one scroll axis: offset register stepped by a signed speed once per frame
//
// Parameters:
//   COORD_W  offset width; arithmetic wraps modulo 2^COORD_W
//   SPEED_W  width of the unsigned speed magnitude (must not exceed COORD_W)
// Ports:
//   clk      pixel clock
//   reset    asynchronous, active-high; clears the offset
//   tick     frame-boundary enable, high for the single cycle whose edge commits the update
//   pause    when high the offset holds even on a tick
//   speed    step magnitude in pixels per frame
//   dir      0 = offset increments, 1 = offset decrements
//   offset   current scroll offset

module vga_scroll_offset #(
    parameter int COORD_W = 10,
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed,
    input  logic               dir,
    output logic [COORD_W-1:0] offset
);

    generate
        if (SPEED_W > COORD_W) begin : g_bad_speed_w
            $error("vga_scroll_offset: SPEED_W must not exceed COORD_W");
        end
    endgenerate

    // Zero-extended magnitude; the subtract path relies on natural
    // two's-complement wrap, so 0 - s lands on 2^COORD_W - s.
    logic [COORD_W-1:0] step;
    assign step = COORD_W'(speed);

    logic [COORD_W-1:0] offset_next;
    assign offset_next = dir ? (offset - step) : (offset + step);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset <= '0;
        end else if (tick && !pause) begin
            offset <= offset_next;
        end
    end

endmodule

// File: rtl/vga_scroll_pattern.sv
// rtl/vga_scroll_pattern.sv - scrolling test-pattern generator between the sync generator and the pin mapping
//
// Build option: VGA_PATTERN_VSCROLL_EN enables vertical scrolling; when undefined the
// vertical offset is a constant 0 and speed_y/dir_y are accepted but ignored.
//
// Parameters:
//   COORD_W  beam coordinate / scroll offset width (>= 6 + COLOR_W)
//   COLOR_W  bits per colour channel
//   SPEED_W  width of the per-axis speed magnitudes
// Ports:
//   clk, reset             pixel clock; asynchronous active-high reset
//   hpos, vpos, display_on beam position and visible-area flag from the sync generator
//   hsync_in, vsync_in     syncs from the sync generator
//   mode                   pattern select, committed only at frame boundaries
//   speed_x/y, dir_x/y     per-axis scroll magnitude and direction (1 = decrement)
//   pause                  freezes both offsets
//   r, g, b                registered colour, one cycle after the beam inputs
//   hsync_out, vsync_out   syncs delayed one cycle to stay aligned with colour
//   frame_tick             one-cycle pulse per vsync rising edge

module vga_scroll_pattern
    import vga_pattern_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 2,
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               display_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [1:0]         mode,
    input  logic [SPEED_W-1:0] speed_x,
    input  logic [SPEED_W-1:0] speed_y,
    input  logic               dir_x,
    input  logic               dir_y,
    input  logic               pause,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               frame_tick
);

    generate
        if (COORD_W < PATTERN_TOP_BASE + COLOR_W) begin : g_bad_coord_w
            $error("vga_scroll_pattern: COORD_W must be at least 6 + COLOR_W");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame boundary detection. vsync_q powers up high so a vsync that is
    // already asserted when reset releases is not mistaken for a new frame.
    // ------------------------------------------------------------------
    logic vsync_q;
    logic boundary;

    assign boundary = vsync_in && !vsync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync_in;
            frame_tick <= boundary;
        end
    end

    // Mode is only committed at the boundary so a mid-frame change never
    // splits one frame across two patterns.
    pattern_mode_t mode_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_s <= CHECKER;
        end else if (boundary) begin
            mode_s <= pattern_mode_t'(mode);
        end
    end

    // ------------------------------------------------------------------
    // Scroll offsets
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] off_x;
    logic [COORD_W-1:0] off_y;

    vga_scroll_offset #(
        .COORD_W (COORD_W),
        .SPEED_W (SPEED_W)
    ) u_off_x (
        .clk    (clk),
        .reset  (reset),
        .tick   (boundary),
        .pause  (pause),
        .speed  (speed_x),
        .dir    (dir_x),
        .offset (off_x)
    );

`ifdef VGA_PATTERN_VSCROLL_EN
    vga_scroll_offset #(
        .COORD_W (COORD_W),
        .SPEED_W (SPEED_W)
    ) u_off_y (
        .clk    (clk),
        .reset  (reset),
        .tick   (boundary),
        .pause  (pause),
        .speed  (speed_y),
        .dir    (dir_y),
        .offset (off_y)
    );
`else
    assign off_y = '0;

    logic vscroll_unused;
    assign vscroll_unused = ^{speed_y, dir_y};
`endif

    // ------------------------------------------------------------------
    // Pattern generation on the scrolled coordinates
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] mx;
    logic [COORD_W-1:0] my;
    logic [COORD_W-1:0] t;

    assign mx = hpos + off_x;
    assign my = vpos + off_y;
    assign t  = mx ^ my;

    // Each pattern reads only a few bits of the scrolled coordinates.
    logic coord_unused;
    assign coord_unused = ^{mx, my, t};

    logic [COLOR_W-1:0] r_n;
    logic [COLOR_W-1:0] g_n;
    logic [COLOR_W-1:0] b_n;

    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (display_on) begin
            case (mode_s)
                CHECKER: begin
                    r_n = {COLOR_W{mx[CHECKER_BIT] ^ my[CHECKER_BIT]}};
                    g_n = r_n;
                    b_n = r_n;
                end
                BARS: begin
                    r_n = mx[BAR_R_BASE +: COLOR_W];
                    g_n = mx[BAR_G_BASE +: COLOR_W];
                    b_n = mx[BAR_B_BASE +: COLOR_W];
                end
                BANDS: begin
                    r_n = my[BAR_R_BASE +: COLOR_W];
                    g_n = my[BAR_G_BASE +: COLOR_W];
                    b_n = my[BAR_B_BASE +: COLOR_W];
                end
                XOR: begin
                    r_n = t[XOR_R_BASE +: COLOR_W];
                    g_n = t[XOR_G_BASE +: COLOR_W];
                    b_n = t[XOR_B_BASE +: COLOR_W];
                end
                default: begin
                    r_n = '0;
                    g_n = '0;
                    b_n = '0;
                end
            endcase
        end
    end

    // Colour and syncs share one register stage so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            r         <= r_n;
            g         <= g_n;
            b         <= b_n;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

endmodule

// File: doc/vga_scroll_pattern.md
# vga_scroll_pattern

Parametrised scrolling test-pattern generator for the TinyVGA output path. It sits between `hvsync_generator` and the `uo_out` pin mapping. It takes the beam position and syncs and produces registered RGB plus delayed syncs. It adds per-axis signed scroll speed, pause, four selectable patterns, and tear-free frame-boundary updates. Scroll state is clocked by `clk` with synchronous vsync edge detection; no logic is clocked by vsync.

## Interface
- `COORD_W`, 10, width of beam coordinates and scroll offsets; must be ≥ 6+`COLOR_W` (elaboration check)
- `COLOR_W`, 2, bits per colour channel
- `SPEED_W`, 4, width of unsigned speed magnitudes (pixels per frame)

- `clk` in 1, pixel clock
- `reset` in 1, asynchronous, active-high
- `hpos`, `vpos` in `COORD_W`, beam position from sync generator
- `display_on` in 1, visible-area flag, same cycle as `hpos`/`vpos`
- `hsync_in`, `vsync_in` in 1, syncs from sync generator
- `mode` in 2, pattern select: 0 CHECKER, 1 BARS, 2 BANDS, 3 XOR
- `speed_x`, `speed_y` in `SPEED_W`, scroll magnitude per frame
- `dir_x`, `dir_y` in 1, 0 = offset increments, 1 = offset decrements
- `pause` in 1, freeze scrolling
- `r`, `g`, `b` out `COLOR_W`, registered colour
- `hsync_out`, `vsync_out` out 1, syncs delayed to match colour
- `frame_tick` out 1, one-cycle pulse per frame boundary

## Operation
- Frame boundary: `vsync_in`=1 while registered `vsync_q`=0. `vsync_q` resets to 1, so a high `vsync_in` at reset release gives no tick.
- At the clock edge ending a boundary cycle:
  - `frame_tick` is set for exactly one cycle.
  - `mode` is latched into `mode_s`.
  - If `pause`=0, each offset updates by ±speed as set by its `dir`, modulo 2^`COORD_W`. Speeds and dirs are sampled at that edge. If `pause`=1, offsets hold.
- `mode_s` and the offsets are constant between ticks. Mid-frame input changes therefore never tear the image.
- Coordinates: `mx`=`hpos`+`off_x` and `my`=`vpos`+`off_y`, both truncated to `COORD_W`.
- Patterns, with W=`COLOR_W`:
  - CHECKER: r=g=b={W{`mx[4]`^`my[4]`}}
  - BARS: r=`mx[4+:W]`, g=`mx[5+:W]`, b=`mx[6+:W]`
  - BANDS: same bit slices taken from `my`
  - XOR: t=`mx`^`my`; r=`t[3+:W]`, g=`t[4+:W]`, b=`t[5+:W]`
- Blanking: if `display_on`=0, r/g/b are 0.

## Timing
- Latency: r/g/b, `hsync_out` and `vsync_out` are registered, 1 cycle after their inputs. Sync alignment is exact.
- Offsets and `mode_s` take their new values on the same edge that raises `frame_tick`. Pixels sampled in the following cycle use the new values.
- Reset (async, any time, including mid-frame) clears r/g/b, `hsync_out`, `vsync_out`, `frame_tick`, `off_x`, `off_y` and `mode_s` to 0, and sets `vsync_q` to 1. Outputs go 0 immediately, without waiting for a clock.
- `vsync_in` held high never retriggers; one tick per rising edge.
- Wrap: an offset of 2^`COORD_W`−1 plus 1 gives 0. Offset 0 minus `speed` gives 2^`COORD_W`−`speed`.
- Speed 0 with `pause`=0 leaves the offset unchanged; `frame_tick` still pulses.

## Configuration
- `VGA_PATTERN_VSCROLL_EN` defined: `off_y` updates from `speed_y`/`dir_y` as described above.
- Macro undefined:
  - `off_y` is a constant 0 with no register.
  - `speed_y`/`dir_y` stay as ports but are ignored.
  - BANDS and XOR use `my`=`vpos`.

## Structure
- Package `vga_pattern_pkg`:
  - `pattern_mode_t` enum (CHECKER, BARS, BANDS, XOR)
  - Pattern bit-position constants (checker bit 4; bar bases 4/5/6; XOR bases 3/4/5)
- Sub-module `vga_scroll_offset`, instantiated per axis: offset register, ±speed modulo update, pause gating, frame-tick enable.

## Test plan
- Reset mid-frame with outputs active: r/g/b/syncs/`frame_tick` go 0 asynchronously. After release with `vsync_in`=1, no tick until `vsync_in` falls and rises again.
- CHECKER, `speed_x`=3, `dir_x`=0, two frames: `off_x`=6. Then `hpos`=10, `vpos`=0, `display_on`=1 gives r=g=b=2'b11 one cycle later.
- `speed_x`=15, `dir_x`=1 from reset: `off_x`=1009 after one tick, 994 after two.
- `pause`=1 across a tick: offsets unchanged, `frame_tick` still pulses once.
- `mode` changed 0→1 mid-frame: output stays CHECKER until the next tick, BARS thereafter.
- `display_on`=0 with non-zero pattern: r/g/b=0. `hsync_out`/`vsync_out` equal inputs delayed 1 cycle. With the macro undefined and `speed_y`=5, `off_y` stays 0.
